// File: rtl/instr_fetch_buffer.sv
// Fetch stage: credit-based issue to a 1-cycle synchronous instruction memory,
// with returned instructions queued (tagged with their PC) in a show-ahead FIFO for decode.
module instr_fetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          pc_addr,
    output logic                       pc_advance,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [DATA_W-1:0]          imem_rdata,
    input  logic                       stall,
    input  logic                       flush,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [DATA_W-1:0]          inst_data,
    output logic [ADDR_W-1:0]          inst_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             head_q, head_d;
    entry_t             incoming;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;

    logic               issue;
    logic               push;
    logic               pop;
    logic [CNT_W:0]     credit_used;

    assign inst_valid = (count_q != '0);
    assign inst_data  = head_q.data;
    assign inst_pc    = head_q.pc;
    assign count      = count_q;
    assign imem_req   = issue;
    assign pc_advance = issue;
    assign imem_addr  = pc_addr;
    assign incoming   = {imem_rdata, req_pc_q};

    // Credits count pre-pop occupancy, so a slot freed this cycle is reused next cycle.
    always_comb begin
        credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        issue       = !reset && !flush && !stall && (credit_used < {1'b0, FULL});
        push        = inflight_q && !flush;
        pop         = inst_valid && inst_ready && !flush;
    end

    // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        inflight_d = issue;
        req_pc_d   = issue ? pc_addr : req_pc_q;
        head_d     = head_q;

        if (push) wptr_d = wptr_q + PTR_W'(1);
        if (pop)  rptr_d = rptr_q + PTR_W'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            rptr_d     = '0;
            wptr_d     = '0;
            count_d    = '0;
            inflight_d = 1'b0;
        end

        // The head register tracks the entry rptr_d will point at; bypass a write landing there.
        if (count_d != '0) begin
            head_d = (push && (wptr_q == rptr_d)) ? incoming : mem_q[rptr_d];
        end
    end

    // NOTE: the entry storage carries no reset; occupancy is governed by count_q and the pointers.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wptr_q] <= incoming;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            req_pc_q   <= '0;
            head_q     <= '0;
        end else begin
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            req_pc_q   <= req_pc_d;
            head_q     <= head_d;
        end
    end

    a_no_write_when_full: assert property (@(posedge clk) disable iff (reset)
        push |-> (count_q != FULL));

    a_credit_bound: assert property (@(posedge clk) disable iff (reset)
        credit_used <= {1'b0, FULL});

    a_no_advance_when_blocked: assert property (@(posedge clk)
        (flush || stall) |-> !pc_advance);

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: upstream PC model, 1-cycle imem model
// returning 0xA0 + address, and one task per scenario with hand-computed expectations.
module tb_instr_fetch_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] pc_addr = '0;
    logic              pc_advance;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata = '0;
    logic              stall;
    logic              flush;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic [2:0]        count;

    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_val;

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_addr    (pc_addr),
        .pc_advance (pc_advance),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .flush      (flush),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_data  (inst_data),
        .inst_pc    (inst_pc),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Upstream PC: redirect load wins over the +4 advance.
    always @(posedge clk) begin
        if (pc_load)         pc_addr <= pc_load_val;
        else if (pc_advance) pc_addr <= pc_addr + 32'd4;
    end

    // Synchronous instruction memory; garbage when no read was issued.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (32'hA0 + imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset(input logic [ADDR_W-1:0] start_pc, input logic ready);
        reset = 1'b1; flush = 1'b0; stall = 1'b0; inst_ready = 1'b0;
        pc_load = 1'b1; pc_load_val = start_pc;
        tick();
        tick();
        reset = 1'b0; pc_load = 1'b0; inst_ready = ready;
        settle();
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; stall = 1'b0; inst_ready = 1'b0;
        pc_load = 1'b1; pc_load_val = '0;
        tick();
        tick();
        n_checks++; if (imem_req !== 1'b0)   $display("FAIL reset_imem_req: got %b want 0", imem_req); else n_pass++;
        n_checks++; if (pc_advance !== 1'b0) $display("FAIL reset_pc_advance: got %b want 0", pc_advance); else n_pass++;
        n_checks++; if (count !== 3'd0)      $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid: got %b want 0", inst_valid); else n_pass++;
        n_checks++; if (inst_data !== 32'h0) $display("FAIL reset_inst_data: got %h want 0", inst_data); else n_pass++;
        n_checks++; if (inst_pc !== 32'h0)   $display("FAIL reset_inst_pc: got %h want 0", inst_pc); else n_pass++;
    endtask

    task automatic test_streaming();
        do_reset(32'h0, 1'b1);
        n_checks++; if (imem_req !== 1'b1)    $display("FAIL stream_first_req: got %b want 1", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== 32'h0)  $display("FAIL stream_first_addr: got %h want 0", imem_addr); else n_pass++;
        tick();
        n_checks++; if (inst_valid !== 1'b0)  $display("FAIL stream_valid_early: got %b want 0", inst_valid); else n_pass++;
        n_checks++; if (imem_addr !== 32'h4)  $display("FAIL stream_second_addr: got %h want 4", imem_addr); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (inst_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", i, inst_valid); else n_pass++;
            n_checks++; if (inst_pc !== 32'(4*i)) $display("FAIL stream_pc[%0d]: got %h want %h", i, inst_pc, 32'(4*i)); else n_pass++;
            n_checks++; if (inst_data !== 32'(32'hA0 + 4*i)) $display("FAIL stream_data[%0d]: got %h want %h", i, inst_data, 32'(32'hA0 + 4*i)); else n_pass++;
            n_checks++; if (count !== 3'd1) $display("FAIL stream_count[%0d]: got %0d want 1", i, count); else n_pass++;
        end
    endtask

    task automatic test_fill_backpressure();
        int pulses;
        pulses = 0;
        do_reset(32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (pc_advance) pulses++;
            tick();
        end
        n_checks++; if (pulses !== DEPTH)    $display("FAIL fill_pulses: got %0d want %0d", pulses, DEPTH); else n_pass++;
        n_checks++; if (count !== 3'd4)      $display("FAIL fill_count: got %0d want 4", count); else n_pass++;
        n_checks++; if (imem_req !== 1'b0)   $display("FAIL fill_req_blocked: got %b want 0", imem_req); else n_pass++;
        inst_ready = 1'b1;
        settle();
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (inst_pc !== 32'(4*k)) $display("FAIL drain_pc[%0d]: got %h want %h", k, inst_pc, 32'(4*k)); else n_pass++;
            n_checks++; if (imem_req !== (k != 0)) $display("FAIL drain_req[%0d]: got %b want %b", k, imem_req, (k != 0)); else n_pass++;
            if (k == 1) begin
                n_checks++; if (imem_addr !== 32'h10) $display("FAIL drain_resume_addr: got %h want 10", imem_addr); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_flush();
        do_reset(32'h10, 1'b0);
        tick();
        tick();
        pc_load = 1'b1; pc_load_val = 32'h100;
        settle();
        n_checks++; if (count !== 3'd1)       $display("FAIL flush_pre_count: got %0d want 1", count); else n_pass++;
        n_checks++; if (imem_addr !== 32'h18) $display("FAIL flush_pre_addr: got %h want 18", imem_addr); else n_pass++;
        tick();
        pc_load = 1'b0; flush = 1'b1;
        settle();
        n_checks++; if (count !== 3'd2)        $display("FAIL flush_cycle_count: got %0d want 2", count); else n_pass++;
        n_checks++; if (inst_pc !== 32'h10)    $display("FAIL flush_cycle_head: got %h want 10", inst_pc); else n_pass++;
        n_checks++; if (imem_req !== 1'b0)     $display("FAIL flush_cycle_req: got %b want 0", imem_req); else n_pass++;
        n_checks++; if (pc_advance !== 1'b0)   $display("FAIL flush_cycle_adv: got %b want 0", pc_advance); else n_pass++;
        tick();
        flush = 1'b0; inst_ready = 1'b1;
        settle();
        n_checks++; if (count !== 3'd0)        $display("FAIL flush_after_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0)   $display("FAIL flush_after_valid: got %b want 0", inst_valid); else n_pass++;
        n_checks++; if (imem_req !== 1'b1)     $display("FAIL flush_resume_req: got %b want 1", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== 32'h100) $display("FAIL flush_resume_addr: got %h want 100", imem_addr); else n_pass++;
        tick();
        n_checks++; if (inst_valid !== 1'b0)   $display("FAIL flush_dropped_0x18: got %b want 0", inst_valid); else n_pass++;
        tick();
        n_checks++; if (inst_pc !== 32'h100)   $display("FAIL flush_new_pc: got %h want 100", inst_pc); else n_pass++;
        n_checks++; if (inst_data !== 32'h1A0) $display("FAIL flush_new_data: got %h want 1a0", inst_data); else n_pass++;
        tick();
        n_checks++; if (inst_pc !== 32'h104)   $display("FAIL flush_next_pc: got %h want 104", inst_pc); else n_pass++;
    endtask

    task automatic test_stall();
        do_reset(32'h200, 1'b1);
        tick();
        tick();
        stall = 1'b1;
        settle();
        for (int s = 0; s < 3; s++) begin
            n_checks++; if (imem_req !== 1'b0)   $display("FAIL stall_req[%0d]: got %b want 0", s, imem_req); else n_pass++;
            n_checks++; if (pc_advance !== 1'b0) $display("FAIL stall_adv[%0d]: got %b want 0", s, pc_advance); else n_pass++;
            n_checks++; if (inst_valid !== (s < 2)) $display("FAIL stall_valid[%0d]: got %b want %b", s, inst_valid, (s < 2)); else n_pass++;
            if (s < 2) begin
                n_checks++; if (inst_pc !== 32'(32'h200 + 4*s)) $display("FAIL stall_pc[%0d]: got %h want %h", s, inst_pc, 32'(32'h200 + 4*s)); else n_pass++;
            end
            tick();
        end
        stall = 1'b0;
        settle();
        n_checks++; if (imem_req !== 1'b1)     $display("FAIL stall_release_req: got %b want 1", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== 32'h208) $display("FAIL stall_release_addr: got %h want 208", imem_addr); else n_pass++;
        tick();
        tick();
        n_checks++; if (inst_pc !== 32'h208)   $display("FAIL stall_cont_pc0: got %h want 208", inst_pc); else n_pass++;
        tick();
        n_checks++; if (inst_pc !== 32'h20C)   $display("FAIL stall_cont_pc1: got %h want 20c", inst_pc); else n_pass++;
    endtask

    task automatic test_push_pop_wrap();
        do_reset(32'h300, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        inst_ready = 1'b1;
        settle();
        n_checks++; if (count !== 3'd3)        $display("FAIL pp_count: got %0d want 3", count); else n_pass++;
        n_checks++; if (imem_req !== 1'b0)     $display("FAIL pp_no_issue: got %b want 0", imem_req); else n_pass++;
        n_checks++; if (inst_pc !== 32'h300)   $display("FAIL pp_head: got %h want 300", inst_pc); else n_pass++;
        tick();
        n_checks++; if (count !== 3'd3)        $display("FAIL pp_count_hold: got %0d want 3", count); else n_pass++;
        n_checks++; if (imem_req !== 1'b1)     $display("FAIL pp_issue_next: got %b want 1", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== 32'h310) $display("FAIL pp_issue_addr: got %h want 310", imem_addr); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (inst_pc !== 32'(32'h304 + 4*k)) $display("FAIL wrap_pc[%0d]: got %h want %h", k, inst_pc, 32'(32'h304 + 4*k)); else n_pass++;
            n_checks++; if (inst_data !== 32'(32'h3A4 + 4*k)) $display("FAIL wrap_data[%0d]: got %h want %h", k, inst_data, 32'(32'h3A4 + 4*k)); else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset(32'h400, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (count !== 3'd2)        $display("FAIL rmid_pre_count: got %0d want 2", count); else n_pass++;
        reset = 1'b1; pc_load = 1'b1; pc_load_val = 32'h500;
        settle();
        n_checks++; if (imem_req !== 1'b0)     $display("FAIL rmid_req: got %b want 0", imem_req); else n_pass++;
        n_checks++; if (pc_advance !== 1'b0)   $display("FAIL rmid_adv: got %b want 0", pc_advance); else n_pass++;
        tick();
        reset = 1'b0; pc_load = 1'b0; inst_ready = 1'b1;
        settle();
        n_checks++; if (count !== 3'd0)        $display("FAIL rmid_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0)   $display("FAIL rmid_valid: got %b want 0", inst_valid); else n_pass++;
        n_checks++; if (inst_data !== 32'h0)   $display("FAIL rmid_data: got %h want 0", inst_data); else n_pass++;
        n_checks++; if (inst_pc !== 32'h0)     $display("FAIL rmid_pc: got %h want 0", inst_pc); else n_pass++;
        n_checks++; if (imem_addr !== 32'h500) $display("FAIL rmid_restart_addr: got %h want 500", imem_addr); else n_pass++;
        n_checks++; if (imem_req !== 1'b1)     $display("FAIL rmid_restart_req: got %b want 1", imem_req); else n_pass++;
        tick();
        n_checks++; if (inst_valid !== 1'b0)   $display("FAIL rmid_no_stale_write: got %b want 0", inst_valid); else n_pass++;
        tick();
        n_checks++; if (inst_pc !== 32'h500)   $display("FAIL rmid_new_pc: got %h want 500", inst_pc); else n_pass++;
        n_checks++; if (inst_data !== 32'h5A0) $display("FAIL rmid_new_data: got %h want 5a0", inst_data); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_fill_backpressure();
        test_flush();
        test_stall();
        test_push_pop_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
- Fetch stage directly downstream of the program counter. It takes the current PC, issues reads to a synchronous instruction memory, and pulses an advance request back to the PC/next-PC logic.
- Returned instructions are buffered, each tagged with its PC, in a small show-ahead FIFO.
- The FIFO is drained by the decode stage over a valid/ready handshake.
- Redirects (branch/jump/reset-vector) are supported by a one-cycle flush.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 32, PC/address width.
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- pc_addr  in  ADDR_W  current PC from the program counter.
- pc_advance  out  1  one-cycle pulse: PC consumed, upstream loads PC+4.
- imem_req  out  1  instruction memory read strobe.
- imem_addr  out  ADDR_W  read address; equals pc_addr.
- imem_rdata  in  DATA_W  read data, valid exactly 1 cycle after imem_req.
- stall  in  1  suppress new fetch issue; buffered entries still drain.
- flush  in  1  discard all buffered and in-flight instructions.
- inst_valid  out  1  FIFO head holds a valid instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- inst_data  out  DATA_W  head instruction.
- inst_pc  out  ADDR_W  PC of head instruction.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
Reset:
- On a clk edge with reset=1: count=0, inst_valid=0, inflight=0, read/write pointers=0, inst_data=0, inst_pc=0.
- While reset=1, imem_req=0 and pc_advance=0.

Issue rule (combinational from registered state):
- issue = !reset & !flush & !stall & (count + inflight < DEPTH).
- imem_req = pc_advance = issue; imem_addr = pc_addr at all times.
- On issue: inflight<=1 and req_pc<=pc_addr. Otherwise inflight<=0.

Throughput and latency:
- Back-to-back issue every cycle is allowed, giving one instruction per cycle at steady state.
- Latency is issue at cycle t, then FIFO write at edge t+1, then inst_valid=1 during cycle t+2.

Write:
- When inflight=1 and flush=0, write {imem_rdata, req_pc} at the write pointer; wptr wraps modulo DEPTH.
- The credit rule guarantees the FIFO is never full on a write. A write to a full FIFO is an assertion failure.

Read:
- Show-ahead: inst_data/inst_pc always reflect the head entry.
- pop = inst_valid & inst_ready. rptr wraps modulo DEPTH.
- inst_valid = (count != 0). Head data is don't-care when invalid; it holds its last value.

Simultaneous push and pop:
- count is unchanged and both pointers advance.
- The credit check uses pre-pop count, which is deliberately conservative. When count + inflight = DEPTH with a pop, no issue occurs that cycle.

Flush:
- In a flush cycle: no issue, pop ignored.
- At the edge: count<=0, rptr<=wptr<=0, inflight<=0.
- Any imem_rdata returning in the flush cycle is dropped.
- Issue resumes the next cycle from the new pc_addr, which upstream has already redirected.
- flush has priority over stall, push and pop.

Other priorities and rules:
- Reset has priority over flush.
- Reset mid-stream behaves like flush, plus the reset values above.
- stall only blocks issue: an in-flight response still writes, and pops continue.
- pc_advance never pulses while reset, flush or stall is asserted.
- Address arithmetic is not performed here; the upstream PC logic owns the increment and wrap (2^ADDR_W wraps to 0).

Test Plan:
1. Streaming: release reset with pc_addr starting 0 and upstream incrementing by 4, imem returning {0x0:0xA0, 0x4:0xA4, ...}, inst_ready=1. Required: first imem_req in the cycle after reset deasserts; inst_valid rises 2 cycles later with inst_pc=0/inst_data=0xA0; then one instruction per cycle with inst_pc=4, 8, 12; count stays at 1.
2. Fill/backpressure: inst_ready=0 for 10 cycles. Required: exactly DEPTH=4 pc_advance pulses, count=4, imem_req=0 afterwards. Then raise inst_ready: entries pop in order (PCs 0, 4, 8, 12), and issue resumes the cycle after count + inflight < 4.
3. Flush with in-flight: buffer holds PCs 0x10, 0x14 with a request for 0x18 in flight; assert flush for 1 cycle while pc_addr=0x100. Required: count=0 the next cycle, 0x18 data never appears, and the next inst_pc is 0x100.
4. Stall: assert stall for 3 cycles mid-stream. Required: no imem_req/pc_advance during the stall, the pending response still enqueued, and PC sequence continuity after release (no gap, no duplicate).
5. Simultaneous push/pop at count=3, inflight=1 (count + inflight = 4 = DEPTH), with inst_ready=1. Required: count stays 3, no issue that cycle, issue occurs the following cycle; pointer wrap from 3 to 0 is exercised with data intact.
6. Reset mid-operation: with count=2, assert reset for 1 cycle. Required: count=0, inst_valid=0, inst_data=0, inst_pc=0, no write from the in-flight response, and normal restart afterwards.
